// File: rtl/note_sequencer.sv
// note_sequencer: plays a captured 3-lane chart one column per beat.
// Ports: clk/reset (sync, active-high), start/pause/abort controls,
//   red_in/blue_in/yellow_in lane bitmaps, total_notes_in note total.
//   Outputs: beat, note_*, window_*, beat_index, notes_emitted,
//   playing, done, and count_mismatch when NOTE_SEQ_COUNT_CHECK_EN
//   is defined (compares emitted notes with the captured total).
module note_sequencer #(
  parameter int SONG_LEN = 100,
  parameter int BEAT_DIV = 12500000,
  parameter int WINDOW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic                abort,
  input  logic [SONG_LEN-1:0] red_in,
  input  logic [SONG_LEN-1:0] blue_in,
  input  logic [SONG_LEN-1:0] yellow_in,
  input  logic [7:0]          total_notes_in,
  output logic                beat,
  output logic                note_red,
  output logic                note_blue,
  output logic                note_yellow,
  output logic [WINDOW-1:0]   window_red,
  output logic [WINDOW-1:0]   window_blue,
  output logic [WINDOW-1:0]   window_yellow,
  output logic [6:0]          beat_index,
  output logic [7:0]          notes_emitted,
  output logic                playing,
  output logic                done
`ifdef NOTE_SEQ_COUNT_CHECK_EN
  ,
  output logic                count_mismatch
`endif
);

  localparam int DW = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam int CW = $clog2(SONG_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SONG_LEN-1:0] red_q, red_d;
  logic [SONG_LEN-1:0] blue_q, blue_d;
  logic [SONG_LEN-1:0] yel_q, yel_d;
  logic [DW-1:0]       div_q, div_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [6:0]          idx_q, idx_d;
  logic [7:0]          ne_q, ne_d;
  logic                nr_q, nr_d;
  logic                nb_q, nb_d;
  logic                ny_q, ny_d;
  logic                beat_q, beat_d;
  logic                play_q, play_d;
  logic                done_q, done_d;
  logic                tc;
  logic [1:0]          pop;
  logic [8:0]          sum;

`ifdef NOTE_SEQ_COUNT_CHECK_EN
  logic [7:0] tot_q, tot_d;
  logic       mis_q, mis_d;
`else
  logic unused_total;
  assign unused_total = ^total_notes_in;
`endif

  assign tc  = (div_q == DW'(BEAT_DIV - 1));
  assign pop = {1'b0, red_q[0]} + {1'b0, blue_q[0]}
             + {1'b0, yel_q[0]};
  assign sum = {1'b0, ne_q} + {7'd0, pop};

  always_comb begin
    state_d = state_q;
    red_d   = red_q;
    blue_d  = blue_q;
    yel_d   = yel_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ne_d    = ne_q;
    nr_d    = nr_q;
    nb_d    = nb_q;
    ny_d    = ny_q;
    beat_d  = 1'b0;
`ifdef NOTE_SEQ_COUNT_CHECK_EN
    tot_d   = tot_q;
    mis_d   = mis_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      red_d   = '0;
      blue_d  = '0;
      yel_d   = '0;
      div_d   = '0;
      cnt_d   = '0;
      idx_d   = '0;
      ne_d    = '0;
      nr_d    = 1'b0;
      nb_d    = 1'b0;
      ny_d    = 1'b0;
`ifdef NOTE_SEQ_COUNT_CHECK_EN
      mis_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          state_d = S_PLAY;
          red_d   = red_in;
          blue_d  = blue_in;
          yel_d   = yellow_in;
          div_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          ne_d    = '0;
          nr_d    = 1'b0;
          nb_d    = 1'b0;
          ny_d    = 1'b0;
`ifdef NOTE_SEQ_COUNT_CHECK_EN
          tot_d   = total_notes_in;
          mis_d   = 1'b0;
`endif
        end
        S_PLAY, S_PAUSE: begin
          // Final column already presented: leave on the next cycle.
          if (state_q == S_PLAY && cnt_q == CW'(SONG_LEN)) begin
            state_d = S_DONE;
            nr_d    = 1'b0;
            nb_d    = 1'b0;
            ny_d    = 1'b0;
`ifdef NOTE_SEQ_COUNT_CHECK_EN
            mis_d   = (ne_q != tot_q);
`endif
          end else if (pause) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_PLAY;
            if (tc) begin
              div_d  = '0;
              nr_d   = red_q[0];
              nb_d   = blue_q[0];
              ny_d   = yel_q[0];
              red_d  = red_q >> 1;
              blue_d = blue_q >> 1;
              yel_d  = yel_q >> 1;
              ne_d   = sum[8] ? 8'hFF : sum[7:0];
              idx_d  = 7'(cnt_q);
              cnt_d  = cnt_q + CW'(1);
              beat_d = 1'b1;
            end else begin
              div_d = div_q + DW'(1);
            end
          end
        end
        S_DONE: begin
          if (start) state_d = S_LOAD;
        end
        default: state_d = S_IDLE;
      endcase
    end
    play_d = (state_d == S_LOAD) || (state_d == S_PLAY)
          || (state_d == S_PAUSE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      red_q   <= '0;
      blue_q  <= '0;
      yel_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ne_q    <= '0;
      nr_q    <= 1'b0;
      nb_q    <= 1'b0;
      ny_q    <= 1'b0;
      beat_q  <= 1'b0;
      play_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NOTE_SEQ_COUNT_CHECK_EN
      tot_q   <= '0;
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      red_q   <= red_d;
      blue_q  <= blue_d;
      yel_q   <= yel_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ne_q    <= ne_d;
      nr_q    <= nr_d;
      nb_q    <= nb_d;
      ny_q    <= ny_d;
      beat_q  <= beat_d;
      play_q  <= play_d;
      done_q  <= done_d;
`ifdef NOTE_SEQ_COUNT_CHECK_EN
      tot_q   <= tot_d;
      mis_q   <= mis_d;
`endif
    end
  end

  assign beat          = beat_q;
  assign note_red      = nr_q;
  assign note_blue     = nb_q;
  assign note_yellow   = ny_q;
  assign window_red    = red_q[WINDOW-1:0];
  assign window_blue   = blue_q[WINDOW-1:0];
  assign window_yellow = yel_q[WINDOW-1:0];
  assign beat_index    = idx_q;
  assign notes_emitted = ne_q;
  assign playing       = play_q;
  assign done          = done_q;
`ifdef NOTE_SEQ_COUNT_CHECK_EN
  assign count_mismatch = mis_q;
`endif

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench for note_sequencer.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_note_sequencer;
  localparam int SL = 100;
  localparam int BD = 4;
  localparam int WN = 16;

  logic          clk = 1'b0;
  logic          reset, start, pause, abort;
  logic [SL-1:0] red_in, blue_in, yellow_in;
  logic [7:0]    total_notes_in;
  logic          beat, note_red, note_blue, note_yellow;
  logic [WN-1:0] window_red, window_blue, window_yellow;
  logic [6:0]    beat_index;
  logic [7:0]    notes_emitted;
  logic          playing, done;
`ifdef NOTE_SEQ_COUNT_CHECK_EN
  logic          count_mismatch;
`endif

  note_sequencer #(
    .SONG_LEN(SL), .BEAT_DIV(BD), .WINDOW(WN)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pause(pause), .abort(abort),
    .red_in(red_in), .blue_in(blue_in),
    .yellow_in(yellow_in),
    .total_notes_in(total_notes_in),
    .beat(beat), .note_red(note_red),
    .note_blue(note_blue), .note_yellow(note_yellow),
    .window_red(window_red), .window_blue(window_blue),
    .window_yellow(window_yellow),
    .beat_index(beat_index),
    .notes_emitted(notes_emitted),
    .playing(playing), .done(done)
`ifdef NOTE_SEQ_COUNT_CHECK_EN
    ,
    .count_mismatch(count_mismatch)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic          r, b, y;
    logic [WN-1:0] wr, wb, wy;
    logic [6:0]    idx;
    logic [7:0]    ne;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (beat === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat @cyc %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("beat_cycle", cyc, mon_e.at);
        chk("note_red", note_red, mon_e.r);
        chk("note_blue", note_blue, mon_e.b);
        chk("note_yellow", note_yellow, mon_e.y);
        chk("window_red", window_red, mon_e.wr);
        chk("window_blue", window_blue, mon_e.wb);
        chk("window_yellow", window_yellow, mon_e.wy);
        chk("beat_index", beat_index, mon_e.idx);
        chk("notes_emitted", notes_emitted, mon_e.ne);
      end
    end
  end

  // Column j is presented BD*(j+1)+2 cycles after start is raised,
  // plus any pause cycles inserted before it.
  task automatic push_song(input logic [SL-1:0] r, b, y,
                           input int s, input int nb,
                           input int pb, input int pl);
    logic [7:0]    ne;
    logic [8:0]    sum;
    logic [SL-1:0] sr, sbl, sy;
    exp_t          e;
    ne = 8'd0;
    for (int j = 0; j < nb; j++) begin
      sr  = r >> (j + 1);
      sbl = b >> (j + 1);
      sy  = y >> (j + 1);
      sum = {1'b0, ne} + 9'(r[j]) + 9'(b[j]) + 9'(y[j]);
      ne  = (sum > 9'd255) ? 8'd255 : sum[7:0];
      e.at  = s + 2 + BD * (j + 1) + ((pb >= 0 && j >= pb) ? pl : 0);
      e.r   = r[j];
      e.b   = b[j];
      e.y   = y[j];
      e.wr  = sr[WN-1:0];
      e.wb  = sbl[WN-1:0];
      e.wy  = sy[WN-1:0];
      e.idx = 7'(j);
      e.ne  = ne;
      sb.push_back(e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic launch(input logic [SL-1:0] r, b, y,
                        input logic [7:0] tot, output int s);
    red_in         = r;
    blue_in        = b;
    yellow_in      = y;
    total_notes_in = tot;
    start          = 1'b1;
    s              = cyc;
    tick();
    start          = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_beat"}, beat, 0);
    chk({tag, "_notes"}, {note_red, note_blue, note_yellow}, 0);
    chk({tag, "_win_r"}, window_red, 0);
    chk({tag, "_win_b"}, window_blue, 0);
    chk({tag, "_win_y"}, window_yellow, 0);
    chk({tag, "_index"}, beat_index, 0);
    chk({tag, "_emitted"}, notes_emitted, 0);
    chk({tag, "_playing"}, playing, 0);
    chk({tag, "_done"}, done, 0);
`ifdef NOTE_SEQ_COUNT_CHECK_EN
    chk({tag, "_mismatch"}, count_mismatch, 0);
`endif
  endtask

  logic [SL-1:0] ra, rb, bb, yb, ones;
  logic          snap_n;
  logic [WN-1:0] snap_w;
  int            s, l, e;

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    pause          = 1'b0;
    abort          = 1'b0;
    red_in         = '0;
    blue_in        = '0;
    yellow_in      = '0;
    total_notes_in = '0;
    for (int i = 0; i < SL; i++) begin
      ra[i] = (i % 2 == 0);
      rb[i] = (i < 90) && (i % 2 == 1);
      yb[i] = (i < 90) && (i % 4 == 0);
      bb[i] = (i < 90) && (i % 4 == 2);
    end
    ones = '1;

    repeat (3) tick();
    @(negedge clk);
    chk_zero("reset");
    tick();
    reset = 1'b0;

    // Alternating red, 10-cycle pause after beat 3, start toggled.
    launch(ra, '0, '0, 8'd50, s);
    push_song(ra, '0, '0, s, 100, 3, 10);
    wait_cyc(s + 10);
    red_in = '0;
    wait_cyc(s + 15);
    pause = 1'b1;
    @(negedge clk);
    snap_n = note_red;
    snap_w = window_red;
    repeat (10) begin
      tick();
      @(negedge clk);
      chk("pause_beat", beat, 0);
      chk("pause_note", note_red, snap_n);
      chk("pause_window", window_red, snap_w);
    end
    pause = 1'b0;
    wait_cyc(s + 40);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    l = s + 2 + BD * 100 + 10;
    wait_cyc(l);
    @(negedge clk);
    chk("a_done_early", done, 0);
    chk("a_playing_last", playing, 1);
    wait_cyc(l + 1);
    @(negedge clk);
    chk("a_done", done, 1);
    chk("a_playing", playing, 0);
    chk("a_emitted", notes_emitted, 50);
    chk("a_index", beat_index, 99);
    chk("a_note_clear", note_red, 0);

    // Mixed chart, total 90 then 91.
    launch(rb, bb, yb, 8'd90, s);
    push_song(rb, bb, yb, s, 100, -1, 0);
    l = s + 2 + BD * 100;
    wait_cyc(l + 1);
    @(negedge clk);
    chk("b_done", done, 1);
    chk("b_emitted", notes_emitted, 90);
`ifdef NOTE_SEQ_COUNT_CHECK_EN
    chk("b_mismatch", count_mismatch, 0);
`endif
    launch(rb, bb, yb, 8'd91, s);
    push_song(rb, bb, yb, s, 100, -1, 0);
    l = s + 2 + BD * 100;
    wait_cyc(l + 1);
    @(negedge clk);
    chk("b2_emitted", notes_emitted, 90);
`ifdef NOTE_SEQ_COUNT_CHECK_EN
    chk("b2_mismatch", count_mismatch, 1);
`endif

    // Abort on the terminal-count cycle of beat 5.
    launch(ra, '0, '0, 8'd50, s);
    push_song(ra, '0, '0, s, 4, -1, 0);
    e = s + 2 + BD * 5;
    wait_cyc(e - 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    chk("abort_pending", sb.size(), 0);

    // Replay from column 0, reset at beat 50.
    launch(ra, '0, '0, 8'd50, s);
    push_song(ra, '0, '0, s, 50, -1, 0);
    e = s + 2 + BD * 50;
    wait_cyc(e);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_zero("midreset");

    // All-ones: saturation and trailing window zeros.
    launch(ones, ones, ones, 8'd0, s);
    push_song(ones, ones, ones, s, 100, -1, 0);
    l = s + 2 + BD * 100;
    wait_cyc(l + 1);
    @(negedge clk);
    chk("d_done", done, 1);
    chk("d_emitted", notes_emitted, 255);
    chk("d_win_r", window_red, 0);
    chk("d_win_y", window_yellow, 0);
`ifdef NOTE_SEQ_COUNT_CHECK_EN
    chk("d_mismatch", count_mismatch, 1);
`endif

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays back a song chart produced by the song loader. On `start`, the block captures the three 100-column lane bitmaps (red, blue, yellow) and the expected note total, then steps through the chart one column per beat. A programmable clock divider sets the beat rate. Each beat it presents the current column's lane notes to the hit-judging logic, and it feeds an upcoming-notes window to the display renderer.

## Interface
- `SONG_LEN`, 100: columns per chart; width of the lane inputs.
- `BEAT_DIV`, 12500000: clock cycles per beat; must be ≥ 2.
- `WINDOW`, 16: upcoming columns exposed per lane; must be ≤ `SONG_LEN`.
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled only in IDLE or DONE.
- `pause`  in  1  level; while high in PLAY, beat timing freezes.
- `abort`  in  1  level; returns the block to IDLE from any state.
- `red_in`, `blue_in`, `yellow_in`  in  `SONG_LEN` each  lane bitmaps; bit 0 is the first column played.
- `total_notes_in`  in  8  expected note total for the chart.
- `beat`  out  1  single-cycle pulse marking a new column on the `note_*` outputs.
- `note_red`, `note_blue`, `note_yellow`  out  1 each  current column's notes; held until the next beat.
- `window_red`, `window_blue`, `window_yellow`  out  `WINDOW` each  bit i = column (next unplayed + i).
- `beat_index`  out  7  index of the column currently presented.
- `notes_emitted`  out  8  running count of set lane bits presented so far; saturates at 255.
- `playing`  out  1  high in LOAD, PLAY and PAUSE.
- `done`  out  1  high in DONE.
- `count_mismatch`  out  1  exists only when the configuration macro is defined.

## Operation
- FSM states: IDLE, LOAD, PLAY, PAUSE, DONE.
- IDLE:
  - `start` = 1 → LOAD.
  - LOAD captures `red_in`, `blue_in`, `yellow_in` into lane shift registers and `total_notes_in` into a holding register.
  - LOAD clears the divider, `beat_index` and `notes_emitted`.
- LOAD → PLAY unconditionally after 1 cycle.
- PLAY:
  - The divider counts 0..`BEAT_DIV`-1.
  - At terminal count: bit 0 of each lane register loads `note_*`, every lane register shifts right with zero fill, `notes_emitted` += (popcount of the 3 notes) with saturation, and `beat` is asserted.
  - `beat_index` = beats presented − 1.
- PLAY ↔ PAUSE:
  - `pause` = 1 → PAUSE. In PAUSE the divider, lane registers and `note_*` hold.
  - `pause` = 0 → PLAY. The divider resumes from its held value.
- After the `SONG_LEN`-th beat, the FSM goes to PLAY → DONE on the cycle following that beat. `note_*` clear to 0 on entry to DONE.
- DONE:
  - `done` stays high.
  - `start` = 1 → LOAD, which restarts with the currently presented inputs.
- `window_*` = lane register bits [`WINDOW`-1:0]. Columns past the end of the chart read as 0.
- `start` is ignored in LOAD, PLAY and PAUSE.
- Priority: `reset` > `abort` > `pause` > beat advance.
  - `abort` on the same cycle as a terminal count: no beat is issued and the FSM goes to IDLE.
  - `abort` → IDLE clears `note_*`, `window_*`, `beat_index`, `notes_emitted`, the divider and the lane registers.
- The lane inputs may change while a song is playing; only the values captured in LOAD are used.

## Timing
- Every output comes from a register.
- Reset values: all outputs 0, FSM in IDLE.
- First `beat` arrives `BEAT_DIV`+1 cycles after the cycle in which `start` was sampled (1 cycle of LOAD plus `BEAT_DIV` cycles of divider).
- Beat spacing is exactly `BEAT_DIV` cycles while in PLAY. Each cycle spent in PAUSE adds one cycle to the spacing.
- `beat` and the updated `note_*`, `window_*`, `beat_index` and `notes_emitted` all appear on the same clock edge.
- `done` rises 1 cycle after the final `beat`.
- `reset` asserted mid-song forces IDLE and all-zero outputs on the next edge.

## Configuration
- `NOTE_SEQ_COUNT_CHECK_EN` defined:
  - On entry to DONE, `count_mismatch` is set when `notes_emitted` ≠ the captured total.
  - `count_mismatch` is cleared by LOAD, `abort` or `reset`.
- Macro undefined: the `count_mismatch` port, the comparator and the total holding register are all absent.

## Test plan
- Start a chart with `BEAT_DIV`=4 and red=alternating …0101, blue=0, yellow=0 → `beat` pulses at cycles 5, 9, 13 after `start`; `note_red` sequence 1,0,1,…; `done` after 100 beats; `notes_emitted`=50.
- Load chart with red=0xAA…, yellow=0x11…, blue=0x44… (each limited to the low 90 columns) and total 90, macro defined → `notes_emitted`=90 and `count_mismatch`=0. Rerun with total 91 → `count_mismatch`=1.
- Hold `pause` for 10 cycles between beats 3 and 4 → spacing between beats 3 and 4 is 14 cycles; `note_*` and `window_*` are unchanged during the pause.
- Assert `abort` on a terminal-count cycle → no `beat` is issued; the next cycle is IDLE with all outputs 0. A following `start` replays from column 0.
- Assert `reset` at beat 50 → all outputs are 0 on the next edge. Toggle `start` during PLAY → no effect.
- All-ones lanes with `SONG_LEN` beats → `notes_emitted` saturates at 255. Over the last 15 beats, the high bits of `window_*` read 0.
